// File: rtl/axi_lite_apb_bridge.sv
module axi_lite_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WRESP,
    ST_RRESP
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] T_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state, next_state;
  logic            last_grant_wr;
  logic [CW-1:0]   tcount;
  logic            wr_elig, rd_elig;
  logic            grant_wr, grant_rd;
  logic            apb_done, apb_abort;

  always_comb begin
    wr_elig   = AWVALID && WVALID;
    rd_elig   = ARVALID;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (state == ST_IDLE && ARESETN) begin
      if (wr_elig && (!rd_elig || !last_grant_wr))
        grant_wr = 1'b1;
      else if (rd_elig)
        grant_rd = 1'b1;
    end
    AWREADY   = grant_wr;
    WREADY    = grant_wr;
    ARREADY   = grant_rd;
    apb_done  = (state == ST_ACCESS) && PREADY;
    apb_abort = (state == ST_ACCESS) && !PREADY && (TIMEOUT != 0) && (tcount == T_LAST);

    next_state = state;
    case (state)
      ST_IDLE:   if (grant_wr || grant_rd) next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (apb_done || apb_abort) next_state = PWRITE ? ST_WRESP : ST_RRESP;
      ST_WRESP:  if (BREADY) next_state = ST_IDLE;
      ST_RRESP:  if (RREADY) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // APB strobes and AXI valids are registered straight from next_state so they
  // track the state register without a separate decode stage.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PWDATA        <= '0;
      PSTRB         <= '0;
      BVALID        <= 1'b0;
      BRESP         <= '0;
      RVALID        <= 1'b0;
      RDATA         <= '0;
      RRESP         <= '0;
      last_grant_wr <= 1'b0;
      tcount        <= '0;
    end else begin
      PSEL    <= (next_state == ST_SETUP) || (next_state == ST_ACCESS);
      PENABLE <= (next_state == ST_ACCESS);
      BVALID  <= (next_state == ST_WRESP);
      RVALID  <= (next_state == ST_RRESP);

      if (grant_wr || grant_rd) begin
        last_grant_wr <= grant_wr;
        PADDR         <= grant_wr ? AWADDR : ARADDR;
        PWRITE        <= grant_wr;
        PWDATA        <= WDATA;
        PSTRB         <= grant_wr ? WSTRB : '0;
      end

      if (state == ST_ACCESS && !PREADY)
        tcount <= tcount + 1'b1;
      else
        tcount <= '0;

      if (apb_done) begin
        if (PWRITE) begin
          BRESP <= {PSLVERR, 1'b0};
        end else begin
          RRESP <= {PSLVERR, 1'b0};
          RDATA <= PRDATA;
        end
      end else if (apb_abort) begin
        if (PWRITE) begin
          BRESP <= 2'b10;
        end else begin
          RRESP <= 2'b10;
          RDATA <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
module tb_axi_lite_apb_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int unsigned passed = 0;
  int unsigned total  = 0;

  axi_lite_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    AWADDR = 32'h40; WDATA = 32'hA5A5A5A5; WSTRB = 4'h3; ARADDR = 32'h44;
    BREADY = 1'b1; RREADY = 1'b1;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0BADF00D;
    tick; tick; tick;
    if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rst_apb actual=%b required=00", {PSEL, PENABLE}); else passed++;
    total++;
    if ({BVALID, RVALID} !== 2'b00) $display("FAIL rst_valid actual=%b required=00", {BVALID, RVALID}); else passed++;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) $display("FAIL rst_ready actual=%b required=000", {AWREADY, WREADY, ARREADY}); else passed++;
    total++;
    if ({PADDR, PWDATA, RDATA} !== 96'h0) $display("FAIL rst_regs actual=%h required=0", {PADDR, PWDATA, RDATA}); else passed++;
    total++;
    if ({PWRITE, PSTRB, BRESP, RRESP} !== 9'h0) $display("FAIL rst_ctl actual=%h required=0", {PWRITE, PSTRB, BRESP, RRESP}); else passed++;
    total++;
  endtask

  task automatic test_arbitration;
    logic exp_wr;
    logic ok;
    ARESETN = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      if ({AWREADY, WREADY, ARREADY} !== {exp_wr, exp_wr, !exp_wr})
        $display("FAIL arb_grant%0d actual=%b required=%b", i, {AWREADY, WREADY, ARREADY}, {exp_wr, exp_wr, !exp_wr});
      else passed++;
      total++;
      tick;
      if ({PWRITE, PADDR} !== {exp_wr, (exp_wr ? 32'h40 : 32'h44)})
        $display("FAIL arb_paddr%0d actual=%b/%h required=%b/%h", i, PWRITE, PADDR, exp_wr, (exp_wr ? 32'h40 : 32'h44));
      else passed++;
      total++;
      tick; tick; tick;
      #1;
    end
    AWVALID = 1'b1; WVALID = 1'b0; ARVALID = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (AWREADY || WREADY || PSEL) ok = 1'b0;
      tick;
    end
    if (ok !== 1'b1) $display("FAIL aw_without_w actual=ready_or_psel required=none"); else passed++;
    total++;
    AWVALID = 1'b0;
  endtask

  task automatic test_write_zero_wait;
    AWADDR = 32'h10; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
    #1;
    if ({AWREADY, WREADY} !== 2'b11) $display("FAIL wr_ready actual=%b required=11", {AWREADY, WREADY}); else passed++;
    total++;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101) $display("FAIL wr_setup actual=%b required=101", {PSEL, PENABLE, PWRITE}); else passed++;
    total++;
    if ({PADDR, PWDATA, PSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF})
      $display("FAIL wr_payload actual=%h/%h/%h required=10/deadbeef/f", PADDR, PWDATA, PSTRB);
    else passed++;
    total++;
    tick;
    if ({PSEL, PENABLE, BVALID} !== 3'b110) $display("FAIL wr_access actual=%b required=110", {PSEL, PENABLE, BVALID}); else passed++;
    total++;
    tick;
    if ({PSEL, PENABLE, BVALID, BRESP} !== 5'b00100) $display("FAIL wr_bresp actual=%b required=00100", {PSEL, PENABLE, BVALID, BRESP}); else passed++;
    total++;
    tick;
    if (BVALID !== 1'b0) $display("FAIL wr_bclear actual=%b required=0", BVALID); else passed++;
    total++;
  endtask

  task automatic test_read_wait;
    ARADDR = 32'h20; ARVALID = 1'b1; RREADY = 1'b1; PREADY = 1'b0; PRDATA = 32'hFFFF0000;
    #1;
    if (ARREADY !== 1'b1) $display("FAIL rd_ready actual=%b required=1", ARREADY); else passed++;
    total++;
    tick;
    ARVALID = 1'b0;
    if ({PSEL, PENABLE, PWRITE, PSTRB, PADDR} !== {3'b100, 4'h0, 32'h20})
      $display("FAIL rd_setup actual=%b/%h/%h required=100/0/20", {PSEL, PENABLE, PWRITE}, PSTRB, PADDR);
    else passed++;
    total++;
    tick;
    for (int k = 0; k < 3; k++) begin
      if ({PSEL, PENABLE, RVALID} !== 3'b110) $display("FAIL rd_wait%0d actual=%b required=110", k, {PSEL, PENABLE, RVALID}); else passed++;
      total++;
      tick;
    end
    PREADY = 1'b1; PRDATA = 32'h12345678;
    if ({PSEL, PENABLE, RVALID} !== 3'b110) $display("FAIL rd_access4 actual=%b required=110", {PSEL, PENABLE, RVALID}); else passed++;
    total++;
    tick;
    PRDATA = 32'hFFFFFFFF;
    if ({PSEL, RVALID, RRESP, RDATA} !== {2'b01, 2'b00, 32'h12345678})
      $display("FAIL rd_rdata actual=%b/%b/%h required=01/00/12345678", {PSEL, RVALID}, RRESP, RDATA);
    else passed++;
    total++;
    tick;
  endtask

  task automatic test_error_backpressure;
    logic ok;
    AWADDR = 32'h30; WDATA = 32'h55AA55AA; WSTRB = 4'h5;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
    #1;
    if (AWREADY !== 1'b1) $display("FAIL err_grant actual=%b required=1", AWREADY); else passed++;
    total++;
    tick;
    AWADDR = 32'h34;
    ok = 1'b1;
    #1; if (AWREADY) ok = 1'b0;
    tick;
    #1; if (AWREADY) ok = 1'b0;
    tick;
    PSLVERR = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (AWREADY || WREADY || !BVALID || BRESP !== 2'b10) ok = 1'b0;
      tick;
    end
    if (ok !== 1'b1) $display("FAIL err_hold actual=unstable required=BVALID=1,BRESP=10,AWREADY=0"); else passed++;
    total++;
    if ({BVALID, BRESP} !== 3'b110) $display("FAIL err_bresp actual=%b required=110", {BVALID, BRESP}); else passed++;
    total++;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    tick;
    if (BVALID !== 1'b0) $display("FAIL err_bclear actual=%b required=0", BVALID); else passed++;
    total++;
  endtask

  task automatic test_timeout;
    int unsigned n;
    ARADDR = 32'h50; ARVALID = 1'b1; RREADY = 1'b1; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
    tick;
    ARVALID = 1'b0;
    tick;
    n = 0;
    while (PENABLE && n < 40) begin
      n++;
      tick;
    end
    if (n !== 16) $display("FAIL to_cycles actual=%0d required=16", n); else passed++;
    total++;
    if ({PSEL, PENABLE, RVALID, RRESP, RDATA} !== {3'b001, 2'b10, 32'h0})
      $display("FAIL to_resp actual=%b/%b/%h required=001/10/0", {PSEL, PENABLE, RVALID}, RRESP, RDATA);
    else passed++;
    total++;
    PREADY = 1'b1;
    tick;
  endtask

  task automatic test_reset_access;
    ARADDR = 32'h60; ARVALID = 1'b1; RREADY = 1'b1; PREADY = 1'b0;
    tick;
    ARVALID = 1'b0;
    tick; tick;
    if ({PSEL, PENABLE} !== 2'b11) $display("FAIL rsta_access actual=%b required=11", {PSEL, PENABLE}); else passed++;
    total++;
    ARESETN = 1'b0;
    tick;
    if ({PSEL, PENABLE, RVALID} !== 3'b000) $display("FAIL rsta_drop actual=%b required=000", {PSEL, PENABLE, RVALID}); else passed++;
    total++;
    ARESETN = 1'b1;
    ARADDR = 32'h64; ARVALID = 1'b1; PREADY = 1'b1; PRDATA = 32'hCAFEF00D;
    #1;
    if (ARREADY !== 1'b1) $display("FAIL rsta_regrant actual=%b required=1", ARREADY); else passed++;
    total++;
    tick;
    ARVALID = 1'b0;
    if (PADDR !== 32'h64) $display("FAIL rsta_paddr actual=%h required=64", PADDR); else passed++;
    total++;
    tick; tick;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'hCAFEF00D})
      $display("FAIL rsta_read actual=%b/%b/%h required=1/00/cafef00d", RVALID, RRESP, RDATA);
    else passed++;
    total++;
    tick;
  endtask

  initial begin
    test_reset;
    test_arbitration;
    test_write_zero_wait;
    test_read_wait;
    test_error_backpressure;
    test_timeout;
    test_reset_access;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_apb_bridge.md
Name: axi_lite_apb_bridge

Overview:
- AXI4-Lite slave to APB master bridge. Sits downstream of axi_master and takes the place of a direct AXI slave, so AXI-Lite traffic can reach APB peripherals.
- Converts each AXI-Lite write or read into exactly one APB transfer, then returns BRESP or RRESP.
- Single outstanding transaction. APB runs on ACLK.

Parameters:
- ADDR_WIDTH, 32, AXI and APB address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  ADDR_WIDTH  write address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  write byte strobes.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  ADDR_WIDTH  read address.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction, 1 = write.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: single clock ACLK. ARESETN is synchronous and active-low. Reset forces state IDLE, last_grant=READ and timeout counter 0.
- Reset values: every registered output is 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, BVALID, BRESP, RVALID, RDATA, RRESP). AWREADY, WREADY and ARREADY are forced 0 while ARESETN is low.
- States: IDLE, SETUP, ACCESS, WRESP, RRESP.
- Write eligibility: AWVALID and WVALID are both high. AW without W, or W without AW, waits; neither ready is asserted.
- Read eligibility: ARVALID is high.
- Ready generation: combinational, Mealy. In IDLE:
  - write granted: AWREADY=WREADY=1 in the same cycle;
  - read granted: ARREADY=1.
  - All readies are 0 in every other state.
- Arbitration: when both are eligible, grant the opposite of last_grant. After reset the write wins. last_grant updates on every grant.
- On grant: register PADDR (AWADDR or ARADDR), PWRITE, PWDATA=WDATA, and PSTRB (WSTRB for a write, 0 for a read). Next state SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - On PREADY=1: capture PSLVERR; for a read, also capture PRDATA into RDATA.
  - Next cycle: PSEL=PENABLE=0; state WRESP (BVALID=1) or RRESP (RVALID=1).
  - PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP through the last ACCESS cycle.
- Timeout: counter increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT (TIMEOUT≠0), abort: drop PSEL and PENABLE, respond SLVERR, RDATA=0. Counter clears on leaving ACCESS.
- Response encoding: BRESP/RRESP = PSLVERR ? 2'b10 : 2'b00.
- WRESP/RRESP: hold BVALID/RVALID and the response and data stable until BREADY/RREADY. Clear valid on the handshake edge and return to IDLE.
  - A new grant is possible in the IDLE cycle that follows.
- Latency: AW/W handshake at cycle T → SETUP at T+1 → ACCESS at T+2 → BVALID at T+3, given PREADY=1 in the first ACCESS cycle. Each PREADY wait state adds 1 cycle.
- Single outstanding transaction: no new AXI handshake occurs before the B or R handshake completes.
- Reset mid-transfer: the synchronous reset drops PSEL, PENABLE, BVALID and RVALID at the next edge. The outstanding transaction is discarded with no response.

Test Plan:
- Write, zero wait: AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF, PREADY=1 → PSEL at T+1, PENABLE at T+2, PWDATA=0xDEADBEEF, PSTRB=0xF, BVALID at T+3 with BRESP=00.
- Read, wait states: ARADDR=0x20, PREADY low 3 cycles, then PREADY=1 with PRDATA=0x12345678 → ACCESS lasts 4 cycles, RDATA=0x12345678, RRESP=00, PSTRB=0.
- Error and backpressure: write with PSLVERR=1 and BREADY held low 5 cycles → BRESP=10, BVALID held stable 5 cycles, AWREADY stays 0 throughout.
- Arbitration: AW, W and AR all valid from reset → write granted first, then read, then alternation on repeated simultaneous requests. AW without W for 4 cycles → no AWREADY.
- Timeout: TIMEOUT=16, PREADY stuck 0 → abort after 16 ACCESS cycles, PSEL drops, RRESP=10, RDATA=0.
- Reset in ACCESS: ARESETN low for 1 cycle mid-transfer → PSEL=PENABLE=0 and RVALID=0 at the next edge; the next read completes normally.
